gamma_lut_loader: RTL and testbench

Writer-side companion to the gamma corrector's LUT write ports. It accepts a table stream from the host/control path over a valid/ready handshake and drives one color plane's `lutNwren`/`lutNval` pair with exactly 2^DATA_WIDTH words. It holds the corrector in bypass (`gcen` low) while any table is incomplete or being rewritten. It sits between the register/DMA front end and the gamma corrector.

---
 rtl/gamma_lut_loader.sv | 178 +++++++++++++++++
 tb/tb_gamma_lut_loader.sv | 285 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/gamma_lut_loader.sv
// Streams one 2^DATA_WIDTH-entry gamma table into a single color plane's LUT write port.
// Optional expected-sum check of the streamed table: define GAMMA_LOADER_CHECKSUM_EN.
module gamma_lut_loader #(
    parameter int unsigned DATA_WIDTH  = 8,
    parameter int unsigned NUM_CP      = 3,
    parameter int unsigned CPSEL_WIDTH = 2,
    parameter int unsigned GUARD       = 4
) (
    input  logic                   clk,
    input  logic                   rstn,
    input  logic                   start,
    input  logic [CPSEL_WIDTH-1:0] load_cp,
    input  logic                   abort,
    input  logic                   s_valid,
    output logic                   s_ready,
    input  logic [DATA_WIDTH-1:0]  s_data,
    output logic [NUM_CP-1:0]      lutwren,
    output logic [DATA_WIDTH-1:0]  lutval,
    output logic                   gcen,
    output logic                   busy,
    output logic                   done,
`ifdef GAMMA_LOADER_CHECKSUM_EN
    input  logic [15:0]            exp_sum,
`endif
    output logic                   err
);

    localparam int unsigned DEPTH = 1 << DATA_WIDTH;
    localparam int unsigned CW    = DATA_WIDTH + 1;
    localparam int unsigned GW    = $clog2(GUARD + 1);

    typedef enum logic [2:0] {IDLE, SETTLE, LOAD, PAD, FINISH} state_t;

    state_t                  state, state_n;
    logic [NUM_CP-1:0]       cp_oh, cp_oh_n;
    logic [NUM_CP-1:0]       tbl_valid, tbl_n;
    logic [CW-1:0]           cnt, cnt_n;
    logic [GW-1:0]           gcnt, gcnt_n;
    logic [NUM_CP-1:0]       wren_n;
    logic [DATA_WIDTH-1:0]   val_n;
    logic                    ready_n, busy_n, gcen_n, done_n, err_n;
    logic                    hs, sum_ok;

`ifdef GAMMA_LOADER_CHECKSUM_EN
    logic [15:0]             sum, sum_n, exp_q, exp_n;
    assign sum_ok = (sum == exp_q);
`else
    assign sum_ok = 1'b1;
`endif

    assign hs = (state == LOAD) && s_valid;

    // Next-state and next-output logic
    always_comb begin
        state_n = state;
        cp_oh_n = cp_oh;
        tbl_n   = tbl_valid;
        cnt_n   = cnt;
        gcnt_n  = gcnt;
        wren_n  = '0;
        val_n   = lutval;
        done_n  = 1'b0;
        err_n   = 1'b0;
`ifdef GAMMA_LOADER_CHECKSUM_EN
        sum_n   = sum;
        exp_n   = exp_q;
`endif
        case (state)
            IDLE: begin
                if (start) begin
                    if (32'(load_cp) < NUM_CP) begin
                        cp_oh_n = NUM_CP'(1) << load_cp;
                        tbl_n   = tbl_valid & ~(NUM_CP'(1) << load_cp);
                        cnt_n   = '0;
                        gcnt_n  = '0;
`ifdef GAMMA_LOADER_CHECKSUM_EN
                        sum_n   = '0;
                        exp_n   = exp_sum;
`endif
                        state_n = SETTLE;
                    end else begin
                        err_n = 1'b1;
                    end
                end
            end
            SETTLE: begin
                if (abort) begin
                    err_n   = 1'b1;
                    state_n = IDLE;
                end else if (gcnt == GW'(GUARD - 1)) begin
                    state_n = LOAD;
                end else begin
                    gcnt_n = gcnt + GW'(1);
                end
            end
            LOAD: begin
                if (hs) begin
                    wren_n = cp_oh;
                    val_n  = s_data;
                    cnt_n  = cnt + CW'(1);
`ifdef GAMMA_LOADER_CHECKSUM_EN
                    sum_n  = sum + 16'(s_data);
`endif
                end
                // A completed table wins over a coincident abort
                if (hs && cnt == CW'(DEPTH - 1)) state_n = FINISH;
                else if (abort)                  state_n = PAD;
            end
            PAD: begin
                // Zero-fill keeps the corrector's write pointer wrapping back to entry 0
                if (cnt == CW'(DEPTH)) begin
                    err_n   = 1'b1;
                    state_n = IDLE;
                end else begin
                    wren_n = cp_oh;
                    val_n  = '0;
                    cnt_n  = cnt + CW'(1);
                end
            end
            FINISH: begin
                if (sum_ok) begin
                    tbl_n  = tbl_valid | cp_oh;
                    done_n = 1'b1;
                end else begin
                    err_n = 1'b1;
                end
                state_n = IDLE;
            end
            default: state_n = IDLE;
        endcase

        if (start && state != IDLE) err_n = 1'b1;

        ready_n = (state_n == LOAD);
        busy_n  = (state_n != IDLE);
        gcen_n  = (&tbl_n) & ~busy_n;
    end

    // State and registered outputs
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state     <= IDLE;
            cp_oh     <= '0;
            tbl_valid <= '0;
            cnt       <= '0;
            gcnt      <= '0;
            s_ready   <= 1'b0;
            lutwren   <= '0;
            lutval    <= '0;
            gcen      <= 1'b0;
            busy      <= 1'b0;
            done      <= 1'b0;
            err       <= 1'b0;
`ifdef GAMMA_LOADER_CHECKSUM_EN
            sum       <= '0;
            exp_q     <= '0;
`endif
        end else begin
            state     <= state_n;
            cp_oh     <= cp_oh_n;
            tbl_valid <= tbl_n;
            cnt       <= cnt_n;
            gcnt      <= gcnt_n;
            s_ready   <= ready_n;
            lutwren   <= wren_n;
            lutval    <= val_n;
            gcen      <= gcen_n;
            busy      <= busy_n;
            done      <= done_n;
            err       <= err_n;
`ifdef GAMMA_LOADER_CHECKSUM_EN
            sum       <= sum_n;
            exp_q     <= exp_n;
`endif
        end
    end

endmodule

// File: tb/tb_gamma_lut_loader.sv
// Self-checking bench for gamma_lut_loader: table of load scenarios plus hand-written corner sequences.
// The corrector LUT is modelled as per-plane arrays with a wrapping write pointer.
`timescale 1ns/1ps
module tb_gamma_lut_loader;

    localparam int DW     = 8;
    localparam int NCP    = 3;
    localparam int CSW    = 2;
    localparam int GUARD  = 4;
    localparam int DEPTH  = 256;
    localparam int BUDGET = 3000;

    logic            clk = 1'b0;
    logic            rstn = 1'b0;
    logic            start = 1'b0;
    logic [CSW-1:0]  load_cp = '0;
    logic            abort = 1'b0;
    logic            s_valid = 1'b0;
    logic            s_ready;
    logic [DW-1:0]   s_data = '0;
    logic [NCP-1:0]  lutwren;
    logic [DW-1:0]   lutval;
    logic            gcen, busy, done, err;
`ifdef GAMMA_LOADER_CHECKSUM_EN
    logic [15:0]     exp_sum = '0;
`endif

    gamma_lut_loader #(.DATA_WIDTH(DW), .NUM_CP(NCP), .CPSEL_WIDTH(CSW), .GUARD(GUARD)) dut (
        .clk(clk), .rstn(rstn), .start(start), .load_cp(load_cp), .abort(abort),
        .s_valid(s_valid), .s_ready(s_ready), .s_data(s_data),
        .lutwren(lutwren), .lutval(lutval), .gcen(gcen), .busy(busy),
        .done(done),
`ifdef GAMMA_LOADER_CHECKSUM_EN
        .exp_sum(exp_sum),
`endif
        .err(err)
    );

    always #5 clk = ~clk;

    int n_chk = 0;
    int n_fail = 0;

    logic [DW-1:0] lut [NCP][DEPTH];
    int            ptr [NCP] = '{0, 0, 0};
    int            wr_cnt [NCP] = '{0, 0, 0};
    bit            tbl_m [NCP] = '{0, 0, 0};
    logic [DW-1:0] data [DEPTH];

    // Corrector-side view: each write enable stores lutval and advances a wrapping pointer
    always @(negedge clk) begin
        if (!rstn) begin
            for (int p = 0; p < NCP; p++) ptr[p] = 0;
        end else begin
            for (int p = 0; p < NCP; p++) begin
                if (lutwren[p]) begin
                    lut[p][ptr[p]] = lutval;
                    ptr[p] = (ptr[p] + 1) % DEPTH;
                    wr_cnt[p]++;
                end
            end
        end
    end

    task automatic chk(input string name, input int act, input int exp);
        n_chk++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk_outputs_zero(input string tag);
        chk({tag, "_s_ready"}, int'(s_ready), 0);
        chk({tag, "_lutwren"}, int'(lutwren), 0);
        chk({tag, "_lutval"},  int'(lutval), 0);
        chk({tag, "_gcen"},    int'(gcen), 0);
        chk({tag, "_busy"},    int'(busy), 0);
        chk({tag, "_done"},    int'(done), 0);
        chk({tag, "_err"},     int'(err), 0);
    endtask

    function automatic bit all_valid();
        bit r = 1'b1;
        for (int p = 0; p < NCP; p++) r &= tbl_m[p];
        return r;
    endfunction

    // mode: 0 = s_valid held high, 1 = random s_valid, 2 = s_valid toggling (high on odd cycles)
    typedef struct {
        int cp;
        bit ramp;
        int mode;
        int abort_at;
        bit abort_hs;
        int start_at;
        int exp_done;
        int exp_err;
        int exp_lat;
        int sum_bias;
    } vec_t;

    task automatic run_and_check(input vec_t v, input string tag);
        int k, idx, n_done, n_err, lat, rdy_k, mism, last, sum;
        int wr0 [NCP];
        bit aborted, hs;
        logic [DW-1:0] expv;

        for (int i = 0; i < DEPTH; i++) data[i] = v.ramp ? DW'(i) : DW'($urandom);
        sum = 0;
        for (int i = 0; i < DEPTH; i++) sum += int'(data[i]);
`ifdef GAMMA_LOADER_CHECKSUM_EN
        exp_sum = 16'(sum + v.sum_bias);
`endif
        for (int p = 0; p < NCP; p++) wr0[p] = wr_cnt[p];
        chk({tag, "_ptr_aligned"}, ptr[v.cp], 0);

        idx = 0; n_done = 0; n_err = 0; lat = 0; rdy_k = 0; aborted = 1'b0;
        load_cp = CSW'(v.cp);
        start = 1'b1;
        step();
        start = 1'b0;
        k = 1;
        chk({tag, "_busy_after_start"}, int'(busy), 1);
        while (k < BUDGET) begin
            if (done) begin n_done++; if (lat == 0) lat = k; end
            if (err) n_err++;
            if (s_ready && rdy_k == 0) rdy_k = k;
            if (!busy) break;
            case (v.mode)
                0:       s_valid = 1'b1;
                1:       s_valid = 1'($urandom_range(0, 1));
                default: s_valid = (k % 2 == 1);
            endcase
            s_data = (idx < DEPTH) ? data[idx] : '0;
            start = (k == v.start_at);
            abort = 1'b0;
            if (v.abort_at >= 0 && idx == v.abort_at && !aborted && s_ready) begin
                abort   = 1'b1;
                s_valid = v.abort_hs;
                aborted = 1'b1;
            end
            hs = s_valid && s_ready;
            step();
            if (hs) idx++;
            k++;
        end
        s_valid = 1'b0; abort = 1'b0; start = 1'b0;
        if (k >= BUDGET) begin
            n_chk++; n_fail++;
            $display("FAIL %s_timeout: load still busy after %0d cycles", tag, BUDGET);
        end

        chk({tag, "_done_pulses"}, n_done, v.exp_done);
        chk({tag, "_err_pulses"}, n_err, v.exp_err);
        for (int p = 0; p < NCP; p++)
            chk({tag, $sformatf("_writes_p%0d", p)}, wr_cnt[p] - wr0[p], (p == v.cp) ? DEPTH : 0);

        last = (v.abort_at < 0) ? DEPTH : (v.abort_hs ? v.abort_at + 1 : v.abort_at);
        mism = 0;
        for (int i = 0; i < DEPTH; i++) begin
            expv = (i < last) ? data[i] : '0;
            if (lut[v.cp][i] !== expv) mism++;
        end
        chk({tag, "_lut_mismatches"}, mism, 0);
        chk({tag, "_first_ready_cycle"}, rdy_k, GUARD + 1);
        if (v.exp_lat != 0) chk({tag, "_done_latency"}, lat, v.exp_lat);

        tbl_m[v.cp] = (v.exp_done == 1);
        chk({tag, "_gcen"}, int'(gcen), int'(all_valid()));
        chk({tag, "_busy_end"}, int'(busy), 0);
    endtask

    localparam int LAT_HELD   = 1 + GUARD + DEPTH + 1;
    localparam int LAT_TOGGLE = 1 + GUARD + (2 * DEPTH - 1) + 1;

    vec_t vecs [9];
    vec_t hv;
    int   w0 [NCP];
    int   idx;
    bit   hs;

    initial begin
        //           cp ramp mode abort hs  start done err lat         bias
        vecs[0] = '{0, 1, 0,  -1,  0, -1,   1,   0,  LAT_HELD,   0};
        vecs[1] = '{1, 1, 2,  -1,  0, -1,   1,   0,  LAT_TOGGLE, 0};
        vecs[2] = '{2, 1, 0,  -1,  0, 60,   1,   1,  LAT_HELD,   0};
        vecs[3] = '{0, 0, 0,  100, 0, -1,   0,   1,  0,          0};
        vecs[4] = '{0, 1, 0,  -1,  0, -1,   1,   0,  LAT_HELD,   0};
        vecs[5] = '{1, 0, 1,  -1,  0, -1,   1,   0,  0,          0};
        vecs[6] = '{2, 0, 1,  0,   0, -1,   0,   1,  0,          0};
        vecs[7] = '{2, 0, 1,  200, 1, -1,   0,   1,  0,          0};
        vecs[8] = '{2, 1, 1,  -1,  0, -1,   1,   0,  0,          0};

        // Reset state
        repeat (3) step();
        chk_outputs_zero("reset");
        rstn = 1'b1;
        repeat (2) step();
        chk_outputs_zero("idle");

        // Out-of-range plane select
        for (int p = 0; p < NCP; p++) w0[p] = wr_cnt[p];
        load_cp = 2'd3;
        start = 1'b1;
        step();
        start = 1'b0;
        chk("badcp_err", int'(err), 1);
        chk("badcp_busy", int'(busy), 0);
        step();
        chk("badcp_err_one_cycle", int'(err), 0);
        chk("badcp_no_writes", wr_cnt[0] + wr_cnt[1] + wr_cnt[2] - w0[0] - w0[1] - w0[2], 0);

        for (int i = 0; i < 9; i++) begin
            run_and_check(vecs[i], $sformatf("vec%0d", i));
            repeat (2) step();
        end

        // Abort during the bypass-settle window: no writes, err pulse, plane invalidated
        for (int p = 0; p < NCP; p++) w0[p] = wr_cnt[p];
        load_cp = 2'd2;
        start = 1'b1;
        step();
        start = 1'b0;
        step();
        abort = 1'b1;
        step();
        abort = 1'b0;
        chk("settle_abort_err", int'(err), 1);
        chk("settle_abort_busy", int'(busy), 0);
        chk("settle_abort_no_writes", wr_cnt[2] - w0[2], 0);
        tbl_m[2] = 1'b0;
        chk("settle_abort_gcen", int'(gcen), 0);
        repeat (2) step();

`ifdef GAMMA_LOADER_CHECKSUM_EN
        hv = '{2, 1, 0, -1, 0, -1, 1, 0, LAT_HELD, 0};
        run_and_check(hv, "csum_good");
        repeat (2) step();
        hv = '{2, 1, 0, -1, 0, -1, 0, 1, 0, 1};
        run_and_check(hv, "csum_bad");
        repeat (2) step();
`endif

        // Reset asserted mid-load after 50 accepted words
        for (int i = 0; i < DEPTH; i++) data[i] = DW'(i);
        load_cp = 2'd0;
        start = 1'b1;
        step();
        start = 1'b0;
        idx = 0;
        for (int j = 0; j < 200 && idx < 50; j++) begin
            s_valid = 1'b1;
            s_data  = data[idx];
            hs = s_ready;
            step();
            if (hs) idx++;
        end
        chk("midrst_words_before_reset", idx, 50);
        chk("midrst_busy_before_reset", int'(busy), 1);
        s_valid = 1'b0;
        #2 rstn = 1'b0;
        #1;
        chk_outputs_zero("midrst");
        repeat (2) @(posedge clk);
        #3 rstn = 1'b1;
        for (int p = 0; p < NCP; p++) tbl_m[p] = 1'b0;
        step();
        chk("postrst_gcen", int'(gcen), 0);
        for (int p = 0; p < NCP; p++) begin
            hv = '{p, 1, 0, -1, 0, -1, 1, 0, LAT_HELD, 0};
            run_and_check(hv, $sformatf("reload_p%0d", p));
            repeat (2) step();
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
